// File: rtl/boxcar_trigger.sv
// Boxcar (moving-window) sum with threshold trigger, hold-off and re-arm hysteresis.
// Define BOXCAR_TRIGGER_TRIG_CNT_EN to build the saturating trigger counter; otherwise trig_cnt is tied to 0.
module boxcar_trigger #(
  parameter int P_NBITS_ADDR = 8,
  parameter int P_NBITS_DATA = 14,
  parameter int P_NBITS_SUM  = P_NBITS_DATA + P_NBITS_ADDR
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_wr,
  input  logic                    in_valid,
  input  logic [P_NBITS_DATA-1:0] qo,
  input  logic [P_NBITS_DATA-1:0] qn,
  input  logic [P_NBITS_SUM-1:0]  thr,
  input  logic [15:0]             holdoff,
  input  logic                    clr,
  output logic [P_NBITS_SUM-1:0]  sum,
  output logic                    sum_valid,
  output logic                    trig,
  output logic [15:0]             trig_cnt,
  output logic                    err
);

  localparam int W = P_NBITS_SUM + 1;

  typedef enum logic [1:0] {IDLE, ARMED, HOLDOFF, REARM} state_t;

  state_t                 state, state_nxt;
  logic [P_NBITS_SUM-1:0] sum_nxt;
  logic                   sum_valid_nxt, trig_nxt, err_nxt;
  logic [15:0]            hcnt, hcnt_nxt;
  logic [W-1:0]           acc, upd;
  logic                   under;

  // One extra bit of headroom: sum+qo cannot overflow and sum+qo<qn is detectable.
  assign acc   = {1'b0, sum} + W'(qo);
  assign under = acc < W'(qn);
  assign upd   = acc - W'(qn);

  always_comb begin
    state_nxt     = state;
    sum_nxt       = sum;
    sum_valid_nxt = sum_valid;
    trig_nxt      = 1'b0;
    err_nxt       = err;
    hcnt_nxt      = hcnt;
    if (clr) begin
      state_nxt     = IDLE;
      sum_nxt       = '0;
      sum_valid_nxt = 1'b0;
      err_nxt       = 1'b0;
      hcnt_nxt      = '0;
    end else if (in_wr) begin
      if (!in_valid) begin
        if (sum_valid) begin
          sum_nxt       = P_NBITS_SUM'(qo);
          sum_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end else begin
          sum_nxt = acc[P_NBITS_SUM-1:0];
        end
      end else begin
        sum_nxt       = under ? '0 : upd[P_NBITS_SUM-1:0];
        err_nxt       = err | under;
        sum_valid_nxt = 1'b1;
        // Thresholds compare against the value sum will show after this update.
        case (state)
          IDLE:  state_nxt = ARMED;
          ARMED: begin
            if (sum_nxt >= thr) begin
              trig_nxt  = 1'b1;
              hcnt_nxt  = holdoff;
              state_nxt = HOLDOFF;
            end
          end
          HOLDOFF: begin
            if (hcnt == '0) state_nxt = REARM;
            else            hcnt_nxt  = hcnt - 16'd1;
          end
          REARM: begin
            if (sum_nxt < thr) state_nxt = ARMED;
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sum       <= '0;
      sum_valid <= 1'b0;
      trig      <= 1'b0;
      err       <= 1'b0;
      hcnt      <= '0;
    end else begin
      state     <= state_nxt;
      sum       <= sum_nxt;
      sum_valid <= sum_valid_nxt;
      trig      <= trig_nxt;
      err       <= err_nxt;
      hcnt      <= hcnt_nxt;
    end
  end

`ifdef BOXCAR_TRIGGER_TRIG_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        trig_cnt <= '0;
    else if (clr)                      trig_cnt <= '0;
    else if (trig_nxt && trig_cnt != '1) trig_cnt <= trig_cnt + 16'd1;
  end
`else
  assign trig_cnt = '0;
`endif

endmodule

// File: tb/tb_boxcar_trigger.sv
// Bench for boxcar_trigger: directed vector table, hand-written reset sequence,
// then randomized traffic through a 4-deep model delay line checked against a window-sum model.
module tb_boxcar_trigger;

  localparam int NS = 22;
  localparam int WIN = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_wr = 1'b0, in_valid = 1'b0, clr = 1'b0;
  logic [13:0]    qo = '0, qn = '0;
  logic [NS-1:0]  thr = '0;
  logic [15:0]    holdoff = '0;
  logic [NS-1:0]  sum;
  logic           sum_valid, trig, err;
  logic [15:0]    trig_cnt;

  int n_checks = 0;
  int n_pass = 0;

  boxcar_trigger #(.P_NBITS_ADDR(8), .P_NBITS_DATA(14), .P_NBITS_SUM(NS)) dut (
    .clk(clk), .rst_n(rst_n), .in_wr(in_wr), .in_valid(in_valid),
    .qo(qo), .qn(qn), .thr(thr), .holdoff(holdoff), .clr(clr),
    .sum(sum), .sum_valid(sum_valid), .trig(trig), .trig_cnt(trig_cnt), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic wr, v, cl;
    int   qo, qn, thr, ho;
    int   e_sum;
    logic e_sv, e_trig, e_err;
    int   e_cnt;
  } vec_t;

  function automatic vec_t mk(logic wr, logic v, logic cl, int qo_i, int qn_i, int thr_i, int ho_i,
                              int e_sum, logic e_sv, logic e_trig, logic e_err, int e_cnt);
    vec_t r;
    r.wr = wr; r.v = v; r.cl = cl; r.qo = qo_i; r.qn = qn_i; r.thr = thr_i; r.ho = ho_i;
    r.e_sum = e_sum; r.e_sv = e_sv; r.e_trig = e_trig; r.e_err = e_err; r.e_cnt = e_cnt;
    return r;
  endfunction

  function automatic int exp_cnt(int c);
`ifdef BOXCAR_TRIGGER_TRIG_CNT_EN
    return c;
`else
    return (c == 0) ? 0 : 0;
`endif
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
  endtask

  task automatic check_outs(string tag, vec_t t);
    chk({tag, ".sum"}, int'(sum), t.e_sum);
    chk({tag, ".sum_valid"}, int'(sum_valid), int'(t.e_sv));
    chk({tag, ".trig"}, int'(trig), int'(t.e_trig));
    chk({tag, ".err"}, int'(err), int'(t.e_err));
    chk({tag, ".trig_cnt"}, int'(trig_cnt), exp_cnt(t.e_cnt));
  endtask

  task automatic apply(string tag, vec_t t);
    @(negedge clk);
    in_wr = t.wr; in_valid = t.v; clr = t.cl;
    qo = t.qo[13:0]; qn = t.qn[13:0]; thr = t.thr[NS-1:0]; holdoff = t.ho[15:0];
    @(posedge clk);
    #1;
    check_outs(tag, t);
  endtask

  vec_t tbl[25];
  int   q[$];

  initial begin
    // Directed table: fill, trigger/hold-off/re-arm, re-prime, underflow, clr vs in_wr.
    tbl[0]  = mk(1,0,0,100,0,1000,0,   100,0,0,0,0);
    tbl[1]  = mk(1,0,0,100,0,1000,0,   200,0,0,0,0);
    tbl[2]  = mk(1,0,0,100,0,1000,0,   300,0,0,0,0);
    tbl[3]  = mk(1,0,0,100,0,1000,0,   400,0,0,0,0);
    tbl[4]  = mk(1,1,0,100,100,1000,0, 400,1,0,0,0);
    tbl[5]  = mk(1,1,0,200,100,500,3,  500,1,1,0,1);
    tbl[6]  = mk(1,1,0,100,100,500,3,  500,1,0,0,1);
    tbl[7]  = mk(1,1,0,100,100,500,3,  500,1,0,0,1);
    tbl[8]  = mk(1,1,0,100,100,500,3,  500,1,0,0,1);
    tbl[9]  = mk(1,1,0,100,100,500,3,  500,1,0,0,1);
    tbl[10] = mk(1,1,0,100,100,500,3,  500,1,0,0,1);
    tbl[11] = mk(1,1,0,100,101,500,3,  499,1,0,0,1);
    tbl[12] = mk(1,1,0,101,100,500,3,  500,1,1,0,2);
    tbl[13] = mk(0,1,0,999,0,0,0,      500,1,0,0,2);
    tbl[14] = mk(1,0,0,7,0,0,0,        7,0,0,0,2);
    tbl[15] = mk(1,0,0,3,0,0,0,        10,0,0,0,2);
    tbl[16] = mk(1,1,0,5,2,0,0,        13,1,0,0,2);
    tbl[17] = mk(1,1,0,0,0,0,0,        13,1,1,0,3);
    tbl[18] = mk(1,1,0,0,0,0,0,        13,1,0,0,3);
    tbl[19] = mk(1,1,0,37,0,1000,0,    50,1,0,0,3);
    tbl[20] = mk(1,1,0,0,100,1000,0,   0,1,0,1,3);
    tbl[21] = mk(1,1,0,5,0,1000,0,     5,1,0,1,3);
    tbl[22] = mk(0,0,0,0,0,1000,0,     5,1,0,1,3);
    tbl[23] = mk(1,1,1,9,0,1000,0,     0,0,0,0,0);
    tbl[24] = mk(1,0,0,9,0,1000,0,     9,0,0,0,0);

    #12;
    check_outs("reset", mk(0,0,0,0,0,0,0, 0,0,0,0,0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) apply($sformatf("tbl%0d", i), tbl[i]);

    // Reset asserted while trig is high must zero everything without a clock edge.
    apply("pre_rst0", mk(1,1,0,1,0,5,0, 10,1,0,0,0));
    apply("pre_rst1", mk(1,1,0,0,0,5,0, 10,1,1,0,1));
    #2 rst_n = 1'b0;
    #1 check_outs("async_rst", mk(0,0,0,0,0,0,0, 0,0,0,0,0));
    @(negedge clk);
    rst_n = 1'b1;
    apply("refill0", mk(1,0,0,4,0,5,0, 4,0,0,0,0));
    apply("refill1", mk(1,1,0,6,4,5,0, 6,1,0,0,0));
    apply("refill2", mk(1,1,0,0,0,5,0, 6,1,1,0,1));
    apply("sync_clr", mk(0,0,1,0,0,0,0, 0,0,0,0,0));

    // Randomized traffic against a window-sum model fed by a WIN-deep delay line.
    begin
      bit m_sv = 0, armed = 0, holding = 0, wait_low = 0, m_err = 0;
      int hold_left = 0, m_sum = 0, m_cnt = 0;
      for (int i = 0; i < 3000; i++) begin
        vec_t t;
        logic wr, cl, v, et;
        int   vqo, vqn, vthr, vho;
        wr   = ($urandom_range(0, 3) != 0);
        cl   = ($urandom_range(0, 63) == 0);
        vthr = 1500 + $urandom_range(0, 1500);
        vho  = $urandom_range(0, 3);
        vqo  = $urandom_range(0, 1000);
        v    = wr ? (q.size() >= WIN) : logic'($urandom_range(0, 1));
        vqn  = (wr && v) ? q[0] : $urandom_range(0, 1000);
        et   = 1'b0;
        if (cl) begin
          q.delete();
          m_sv = 0; armed = 0; holding = 0; wait_low = 0; m_err = 0;
          hold_left = 0; m_sum = 0; m_cnt = 0;
        end else if (wr) begin
          q.push_back(vqo);
          if (q.size() > WIN) void'(q.pop_front());
          m_sum = 0;
          foreach (q[k]) m_sum += q[k];
          if (v) begin
            if (!m_sv) armed = 1;
            else if (armed) begin
              if (m_sum >= vthr) begin
                et = 1'b1; armed = 0; holding = 1; hold_left = vho;
                if (m_cnt < 65535) m_cnt++;
              end
            end else if (holding) begin
              if (hold_left == 0) begin holding = 0; wait_low = 1; end
              else hold_left--;
            end else if (wait_low) begin
              if (m_sum < vthr) begin wait_low = 0; armed = 1; end
            end
            m_sv = 1;
          end
        end
        t = mk(wr, v, cl, vqo, vqn, vthr, vho, m_sum, m_sv, et, m_err, m_cnt);
        apply($sformatf("rnd%0d", i), t);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

endmodule
